// File: rtl/tcam_result_queue_if.sv
// Result-queue bus for tcam_result_queue: search/result inputs from the match
// engine, the FWFT result handshake, and the status/statistics outputs.
interface tcam_result_queue_if #(
   parameter int IDWID  = 8,
   parameter int QAWID  = 4,
   parameter int CNTWID = 16
);
   logic              i_search;
   logic              i_valid;
   logic [IDWID-1:0]  i_ruleid;
   logic              i_clr;
   logic              o_res_valid;
   logic              i_res_ready;
   logic              o_res_hit;
   logic [IDWID-1:0]  o_res_ruleid;
   logic [QAWID:0]    o_level;
   logic              o_overflow;
   logic              o_proterr;
   logic [CNTWID-1:0] o_hit_cnt;
   logic [CNTWID-1:0] o_miss_cnt;
   logic [CNTWID-1:0] o_drop_cnt;

   modport master (
      output i_search, i_valid, i_ruleid, i_clr, i_res_ready,
      input  o_res_valid, o_res_hit, o_res_ruleid, o_level,
      input  o_overflow, o_proterr, o_hit_cnt, o_miss_cnt, o_drop_cnt
   );

   modport slave (
      input  i_search, i_valid, i_ruleid, i_clr, i_res_ready,
      output o_res_valid, o_res_hit, o_res_ruleid, o_level,
      output o_overflow, o_proterr, o_hit_cnt, o_miss_cnt, o_drop_cnt
   );
endinterface

// File: rtl/tcam_result_queue.sv
// Aligns TCAM match results to their searches and queues them in a FWFT FIFO.
// Hit/miss/drop statistics exist only when TCAM_RESULT_STATS_EN is defined.
module tcam_result_queue #(
   parameter int IDWID  = 8,
   parameter int LAT    = 5,
   parameter int QAWID  = 4,
   parameter int CNTWID = 16
) (
   input logic clk,
   input logic rst,
   tcam_result_queue_if.slave bus
);
   localparam int QDEP = 1 << QAWID;
   localparam logic [QAWID:0]   LVL_FULL = (QAWID+1)'(QDEP);
   localparam logic [QAWID:0]   LVL_ONE  = (QAWID+1)'(1'b1);
   localparam logic [QAWID-1:0] PTR_ONE  = (QAWID)'(1'b1);

   logic [LAT-1:0]   pipe_r;
   logic [IDWID:0]   mem_r [QDEP];
   logic [QAWID-1:0] wr_ptr_r;
   logic [QAWID-1:0] rd_ptr_r;
   logic [QAWID:0]   level_r;
   logic [QAWID:0]   level_next_s;
   logic             overflow_r;
   logic             proterr_r;
   logic             tag_s;
   logic             full_s;
   logic             empty_s;
   logic             pop_s;
   logic             write_s;
   logic             drop_s;
   logic             proterr_ev_s;
   logic [IDWID:0]   entry_s;
   logic [IDWID:0]   head_s;

   // Search tag pipeline; the bit leaving the last stage lines up with i_valid.
   generate
      if (LAT == 1) begin : g_pipe1
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) pipe_r <= 1'b0;
            else      pipe_r <= bus.i_search;
         end
      end else begin : g_pipen
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) pipe_r <= {LAT{1'b0}};
            else      pipe_r <= {pipe_r[LAT-2:0], bus.i_search};
         end
      end
   endgenerate

   // Push/pop/drop decisions and next queue level.
   always_comb begin
      tag_s        = pipe_r[LAT-1];
      full_s       = (level_r == LVL_FULL);
      empty_s      = (level_r == {(QAWID+1){1'b0}});
      pop_s        = !empty_s && bus.i_res_ready;
      write_s      = tag_s && (!full_s || pop_s);
      drop_s       = tag_s && full_s && !pop_s;
      proterr_ev_s = !tag_s && bus.i_valid;
      if (bus.i_valid) entry_s = {1'b1, bus.i_ruleid};
      else             entry_s = {(IDWID+1){1'b0}};
      head_s = mem_r[rd_ptr_r];
      case ({write_s, pop_s})
         2'b10:   level_next_s = level_r + LVL_ONE;
         2'b01:   level_next_s = level_r - LVL_ONE;
         default: level_next_s = level_r;
      endcase
   end

   // Queue storage carries no reset; only the level decides what is valid.
   always_ff @(posedge clk) begin
      if (write_s) mem_r[wr_ptr_r] <= entry_s;
   end

   // Pointers and level are untouched by i_clr.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= {QAWID{1'b0}};
         rd_ptr_r <= {QAWID{1'b0}};
         level_r  <= {(QAWID+1){1'b0}};
      end else begin
         if (write_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_s)   rd_ptr_r <= rd_ptr_r + PTR_ONE;
         level_r <= level_next_s;
      end
   end

   // Sticky error flags; a coincident clear takes priority over a new event.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_r <= 1'b0;
         proterr_r  <= 1'b0;
      end else if (bus.i_clr) begin
         overflow_r <= 1'b0;
         proterr_r  <= 1'b0;
      end else begin
         if (drop_s)       overflow_r <= 1'b1;
         if (proterr_ev_s) proterr_r  <= 1'b1;
      end
   end

   // Head presentation; ruleid and hit read as zero while the queue is empty.
   always_comb begin
      bus.o_res_valid = !empty_s;
      if (empty_s) begin
         bus.o_res_hit    = 1'b0;
         bus.o_res_ruleid = {IDWID{1'b0}};
      end else begin
         bus.o_res_hit    = head_s[IDWID];
         bus.o_res_ruleid = head_s[IDWID-1:0];
      end
   end

   assign bus.o_level    = level_r;
   assign bus.o_overflow = overflow_r;
   assign bus.o_proterr  = proterr_r;

`ifdef TCAM_RESULT_STATS_EN
   localparam logic [CNTWID-1:0] CNT_MAX = {CNTWID{1'b1}};
   localparam logic [CNTWID-1:0] CNT_ONE = (CNTWID)'(1'b1);

   logic [CNTWID-1:0] hit_cnt_r;
   logic [CNTWID-1:0] miss_cnt_r;
   logic [CNTWID-1:0] drop_cnt_r;

   // Saturating statistics; dropped results still count as hit or miss.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt_r  <= {CNTWID{1'b0}};
         miss_cnt_r <= {CNTWID{1'b0}};
         drop_cnt_r <= {CNTWID{1'b0}};
      end else if (bus.i_clr) begin
         hit_cnt_r  <= {CNTWID{1'b0}};
         miss_cnt_r <= {CNTWID{1'b0}};
         drop_cnt_r <= {CNTWID{1'b0}};
      end else begin
         if (tag_s && bus.i_valid && (hit_cnt_r != CNT_MAX))
            hit_cnt_r <= hit_cnt_r + CNT_ONE;
         if (tag_s && !bus.i_valid && (miss_cnt_r != CNT_MAX))
            miss_cnt_r <= miss_cnt_r + CNT_ONE;
         if (drop_s && (drop_cnt_r != CNT_MAX))
            drop_cnt_r <= drop_cnt_r + CNT_ONE;
      end
   end

   assign bus.o_hit_cnt  = hit_cnt_r;
   assign bus.o_miss_cnt = miss_cnt_r;
   assign bus.o_drop_cnt = drop_cnt_r;
`else
   assign bus.o_hit_cnt  = {CNTWID{1'b0}};
   assign bus.o_miss_cnt = {CNTWID{1'b0}};
   assign bus.o_drop_cnt = {CNTWID{1'b0}};
`endif
endmodule

// File: tb/tb_tcam_result_queue.sv
// Directed self-checking bench for tcam_result_queue (LAT=5, 16-deep queue,
// 4-bit counters so saturation is reachable); counters expect 0 without stats.
module tb_tcam_result_queue;
   localparam int IDWID  = 8;
   localparam int LAT    = 5;
   localparam int QAWID  = 4;
   localparam int CNTWID = 4;
`ifdef TCAM_RESULT_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   nchk = 0;
   int   nfail = 0;

   tcam_result_queue_if #(.IDWID(IDWID), .QAWID(QAWID), .CNTWID(CNTWID)) bus ();

   tcam_result_queue #(.IDWID(IDWID), .LAT(LAT), .QAWID(QAWID), .CNTWID(CNTWID)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [CNTWID-1:0] cexp(input int n);
      if (!STATS) return '0;
      if (n > 15) return 4'hF;
      return n[CNTWID-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_clr();
      bus.i_clr = 1'b1;
      tick();
      bus.i_clr = 1'b0;
   endtask

   task automatic test_reset();
      bus.i_search = 1'b0; bus.i_valid = 1'b0; bus.i_ruleid = 8'h00;
      bus.i_clr = 1'b0; bus.i_res_ready = 1'b0;
      #12;
      nchk++; if (bus.o_res_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid: got %0h expected 0", bus.o_res_valid); end
      nchk++; if (bus.o_res_ruleid !== 8'h00) begin nfail++; $display("FAIL reset_ruleid: got %0h expected 0", bus.o_res_ruleid); end
      nchk++; if (bus.o_level !== 5'd0) begin nfail++; $display("FAIL reset_level: got %0d expected 0", bus.o_level); end
      nchk++; if ({bus.o_overflow, bus.o_proterr} !== 2'b00) begin nfail++; $display("FAIL reset_flags: got %b expected 00", {bus.o_overflow, bus.o_proterr}); end
      nchk++; if ({bus.o_hit_cnt, bus.o_miss_cnt, bus.o_drop_cnt} !== 12'h000) begin nfail++; $display("FAIL reset_cnt: got %0h expected 0", {bus.o_hit_cnt, bus.o_miss_cnt, bus.o_drop_cnt}); end
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_single_hit();
      bus.i_search = 1'b1;
      tick();
      bus.i_search = 1'b0;
      repeat (4) tick();
      nchk++; if (bus.o_res_valid !== 1'b0) begin nfail++; $display("FAIL hit_early_valid: got %0h expected 0", bus.o_res_valid); end
      bus.i_valid = 1'b1; bus.i_ruleid = 8'h2A;
      tick();
      bus.i_valid = 1'b0; bus.i_ruleid = 8'h00;
      nchk++; if (bus.o_res_valid !== 1'b1) begin nfail++; $display("FAIL hit_valid: got %0h expected 1", bus.o_res_valid); end
      nchk++; if (bus.o_res_hit !== 1'b1) begin nfail++; $display("FAIL hit_flag: got %0h expected 1", bus.o_res_hit); end
      nchk++; if (bus.o_res_ruleid !== 8'h2A) begin nfail++; $display("FAIL hit_ruleid: got %0h expected 2a", bus.o_res_ruleid); end
      nchk++; if (bus.o_hit_cnt !== cexp(1)) begin nfail++; $display("FAIL hit_cnt: got %0h expected %0h", bus.o_hit_cnt, cexp(1)); end
      tick();
      nchk++; if (bus.o_res_ruleid !== 8'h2A || bus.o_res_valid !== 1'b1) begin nfail++; $display("FAIL hit_hold: got %0h expected 2a", bus.o_res_ruleid); end
      bus.i_res_ready = 1'b1;
      tick();
      bus.i_res_ready = 1'b0;
      nchk++; if (bus.o_res_valid !== 1'b0 || bus.o_res_ruleid !== 8'h00) begin nfail++; $display("FAIL hit_popped: got %0h/%0h expected 0/0", bus.o_res_valid, bus.o_res_ruleid); end
   endtask

   task automatic test_miss();
      pulse_clr();
      bus.i_search = 1'b1;
      tick();
      bus.i_search = 1'b0;
      repeat (5) tick();
      nchk++; if (bus.o_res_valid !== 1'b1 || bus.o_res_hit !== 1'b0) begin nfail++; $display("FAIL miss_entry: got valid %0h hit %0h expected 1/0", bus.o_res_valid, bus.o_res_hit); end
      nchk++; if (bus.o_res_ruleid !== 8'h00) begin nfail++; $display("FAIL miss_ruleid: got %0h expected 0", bus.o_res_ruleid); end
      nchk++; if (bus.o_miss_cnt !== cexp(1) || bus.o_hit_cnt !== cexp(0)) begin nfail++; $display("FAIL miss_cnt: got %0h/%0h expected %0h/%0h", bus.o_miss_cnt, bus.o_hit_cnt, cexp(1), cexp(0)); end
      bus.i_res_ready = 1'b1;
      tick();
      bus.i_res_ready = 1'b0;
      nchk++; if (bus.o_level !== 5'd0) begin nfail++; $display("FAIL miss_level: got %0d expected 0", bus.o_level); end
   endtask

   task automatic test_full();
      pulse_clr();
      bus.i_res_ready = 1'b0;
      for (int c = 0; c < 18 + LAT; c++) begin
         bus.i_search = (c < 18);
         bus.i_valid  = (c >= LAT) && (c < 18 + LAT);
         bus.i_ruleid = bus.i_valid ? 8'(c - LAT + 1) : 8'h00;
         tick();
      end
      bus.i_search = 1'b0; bus.i_valid = 1'b0; bus.i_ruleid = 8'h00;
      nchk++; if (bus.o_level !== 5'd16) begin nfail++; $display("FAIL full_level: got %0d expected 16", bus.o_level); end
      nchk++; if (bus.o_overflow !== 1'b1) begin nfail++; $display("FAIL full_overflow: got %0h expected 1", bus.o_overflow); end
      nchk++; if (bus.o_drop_cnt !== cexp(2)) begin nfail++; $display("FAIL full_drop_cnt: got %0h expected %0h", bus.o_drop_cnt, cexp(2)); end
      nchk++; if (bus.o_hit_cnt !== cexp(18)) begin nfail++; $display("FAIL full_hit_cnt: got %0h expected %0h", bus.o_hit_cnt, cexp(18)); end
      bus.i_res_ready = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         nchk++; if (bus.o_res_valid !== 1'b1 || bus.o_res_ruleid !== 8'(k)) begin nfail++; $display("FAIL full_drain[%0d]: got %0h/%0h expected 1/%0h", k, bus.o_res_valid, bus.o_res_ruleid, k); end
         tick();
      end
      bus.i_res_ready = 1'b0;
      nchk++; if (bus.o_res_valid !== 1'b0 || bus.o_level !== 5'd0) begin nfail++; $display("FAIL full_empty: got %0h/%0d expected 0/0", bus.o_res_valid, bus.o_level); end
   endtask

   task automatic test_push_pop_full();
      pulse_clr();
      for (int c = 0; c < 17 + LAT; c++) begin
         bus.i_search    = (c < 17);
         bus.i_valid     = (c >= LAT) && (c < 17 + LAT);
         bus.i_ruleid    = bus.i_valid ? 8'(8'h40 + c - LAT + 1) : 8'h00;
         bus.i_res_ready = (c == 16 + LAT);
         if (c == 16 + LAT) begin
            nchk++; if (bus.o_level !== 5'd16) begin nfail++; $display("FAIL pp_pre_level: got %0d expected 16", bus.o_level); end
         end
         tick();
      end
      bus.i_search = 1'b0; bus.i_valid = 1'b0; bus.i_ruleid = 8'h00; bus.i_res_ready = 1'b0;
      nchk++; if (bus.o_level !== 5'd16) begin nfail++; $display("FAIL pp_level: got %0d expected 16", bus.o_level); end
      nchk++; if (bus.o_overflow !== 1'b0 || bus.o_drop_cnt !== cexp(0)) begin nfail++; $display("FAIL pp_nodrop: got %0h/%0h expected 0/0", bus.o_overflow, bus.o_drop_cnt); end
      bus.i_res_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         nchk++; if (bus.o_res_ruleid !== 8'(8'h42 + k)) begin nfail++; $display("FAIL pp_drain[%0d]: got %0h expected %0h", k, bus.o_res_ruleid, 8'h42 + k); end
         tick();
      end
      bus.i_res_ready = 1'b0;
      nchk++; if (bus.o_level !== 5'd0) begin nfail++; $display("FAIL pp_empty: got %0d expected 0", bus.o_level); end
   endtask

   task automatic test_proterr();
      bus.i_valid = 1'b1; bus.i_ruleid = 8'h77;
      tick();
      bus.i_valid = 1'b0; bus.i_ruleid = 8'h00;
      nchk++; if (bus.o_proterr !== 1'b1) begin nfail++; $display("FAIL perr_set: got %0h expected 1", bus.o_proterr); end
      nchk++; if (bus.o_level !== 5'd0 || bus.o_res_valid !== 1'b0) begin nfail++; $display("FAIL perr_nowrite: got %0d expected 0", bus.o_level); end
      pulse_clr();
      nchk++; if (bus.o_proterr !== 1'b0 || bus.o_overflow !== 1'b0) begin nfail++; $display("FAIL perr_clr: got %0h/%0h expected 0/0", bus.o_proterr, bus.o_overflow); end
      nchk++; if ({bus.o_hit_cnt, bus.o_miss_cnt, bus.o_drop_cnt} !== 12'h000) begin nfail++; $display("FAIL perr_clr_cnt: got %0h expected 0", {bus.o_hit_cnt, bus.o_miss_cnt, bus.o_drop_cnt}); end
      bus.i_valid = 1'b1; bus.i_clr = 1'b1;
      tick();
      bus.i_valid = 1'b0; bus.i_clr = 1'b0;
      nchk++; if (bus.o_proterr !== 1'b0) begin nfail++; $display("FAIL perr_clr_wins: got %0h expected 0", bus.o_proterr); end
   endtask

   task automatic test_saturation();
      pulse_clr();
      bus.i_res_ready = 1'b1;
      for (int c = 0; c < 20 + LAT; c++) begin
         bus.i_search = (c < 20);
         bus.i_valid  = (c >= LAT) && (c < 20 + LAT);
         bus.i_ruleid = bus.i_valid ? 8'(c - LAT + 1) : 8'h00;
         tick();
      end
      bus.i_search = 1'b0; bus.i_valid = 1'b0; bus.i_ruleid = 8'h00;
      nchk++; if (bus.o_level !== 5'd1 || bus.o_res_ruleid !== 8'd20) begin nfail++; $display("FAIL sat_level1: got %0d/%0h expected 1/14", bus.o_level, bus.o_res_ruleid); end
      nchk++; if (bus.o_hit_cnt !== cexp(20)) begin nfail++; $display("FAIL sat_hit_cnt: got %0h expected %0h", bus.o_hit_cnt, cexp(20)); end
      nchk++; if (bus.o_miss_cnt !== cexp(0) || bus.o_drop_cnt !== cexp(0) || bus.o_overflow !== 1'b0) begin nfail++; $display("FAIL sat_others: got %0h/%0h/%0h expected 0/0/0", bus.o_miss_cnt, bus.o_drop_cnt, bus.o_overflow); end
      tick();
      bus.i_res_ready = 1'b0;
      nchk++; if (bus.o_level !== 5'd0) begin nfail++; $display("FAIL sat_empty: got %0d expected 0", bus.o_level); end
   endtask

   task automatic test_reset_inflight();
      bus.i_search = 1'b1;
      tick();
      bus.i_search = 1'b0;
      tick();
      rst = 1'b0;
      #2;
      nchk++; if (bus.o_res_valid !== 1'b0 || bus.o_proterr !== 1'b0) begin nfail++; $display("FAIL rif_async: got %0h/%0h expected 0/0", bus.o_res_valid, bus.o_proterr); end
      tick();
      rst = 1'b1;
      repeat (2) tick();
      bus.i_valid = 1'b1; bus.i_ruleid = 8'h55;
      tick();
      bus.i_valid = 1'b0; bus.i_ruleid = 8'h00;
      nchk++; if (bus.o_proterr !== 1'b1) begin nfail++; $display("FAIL rif_proterr: got %0h expected 1", bus.o_proterr); end
      nchk++; if (bus.o_level !== 5'd0) begin nfail++; $display("FAIL rif_level: got %0d expected 0", bus.o_level); end
   endtask

   initial begin
      test_reset();
      test_single_hit();
      test_miss();
      test_full();
      test_push_pop_full();
      test_proterr();
      test_saturation();
      test_reset_inflight();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule
